// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - EX-stage multiply/divide unit with HI/LO result registers
// Optional multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU) are built when EX_MULDIV_MADD_EN is defined.
module ex_muldiv #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] opa_i,
  input  logic [DATA_W-1:0] opb_i,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  input  logic              annul_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              whilo_o
);

  localparam int CW       = $clog2(DATA_W + 1);
  localparam int MUL_LAST = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
`ifdef EX_MULDIV_MADD_EN
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [2*DATA_W-1:0] acc_src;
`endif

  logic                  in_idle;
  logic                  op_valid;
  logic                  accept;
  logic                  is_div_in;
  logic                  div_zero_in;
  logic                  sgn_in;
  logic [DATA_W-1:0]     a_mag;
  logic [DATA_W-1:0]     b_mag;
  logic [2:0]            src_op;
  logic [DATA_W-1:0]     src_a;
  logic [DATA_W-1:0]     src_b;
  logic                  mul_sgn;
  logic [2*DATA_W-1:0]   a_ext;
  logic [2*DATA_W-1:0]   b_ext;
  logic [2*DATA_W-1:0]   product;
  logic [2*DATA_W-1:0]   mac;
  logic [DATA_W:0]       rem_shift;
  logic [DATA_W:0]       diff;
  logic                  borrow;
  logic [DATA_W-1:0]     step_rem;
  logic [DATA_W-1:0]     step_quo;
  logic [DATA_W-1:0]     rem_fix;
  logic [DATA_W-1:0]     quo_fix;

  always_comb begin
    in_idle     = (state_q == S_IDLE);
`ifdef EX_MULDIV_MADD_EN
    op_valid    = 1'b1;
`else
    op_valid    = ~op_i[2];
`endif
    accept      = in_idle && start_i && op_valid && !annul_i;
    is_div_in   = (op_i[2:1] == 2'b01);
    div_zero_in = is_div_in && (opb_i == '0);
    sgn_in      = ~op_i[0];
    a_mag       = (sgn_in && opa_i[DATA_W-1]) ? -opa_i : opa_i;
    b_mag       = (sgn_in && opb_i[DATA_W-1]) ? -opb_i : opb_i;
  end

  // In IDLE the multiplier sees the live inputs so MUL_LAT=1 can finish on the accept edge.
  always_comb begin
    src_op  = in_idle ? op_i  : op_q;
    src_a   = in_idle ? opa_i : a_q;
    src_b   = in_idle ? opb_i : b_q;
    mul_sgn = ~src_op[0];
    a_ext   = {{DATA_W{mul_sgn & src_a[DATA_W-1]}}, src_a};
    b_ext   = {{DATA_W{mul_sgn & src_b[DATA_W-1]}}, src_b};
    product = a_ext * b_ext;
  end

`ifdef EX_MULDIV_MADD_EN
  always_comb begin
    acc_src = in_idle ? {hi_i, lo_i} : acc_q;
    if (!src_op[2]) begin
      mac = product;
    end else if (src_op[1]) begin
      mac = acc_src - product;
    end else begin
      mac = acc_src + product;
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{hi_i, lo_i, src_op[2:1]};
  assign mac = product;
`endif

  // One restoring step: shift in the next dividend bit, keep the difference if it did not borrow.
  always_comb begin
    rem_shift = {rem_q, quo_q[DATA_W-1]};
    diff      = rem_shift - {1'b0, dvs_q};
    borrow    = diff[DATA_W];
    step_rem  = borrow ? rem_shift[DATA_W-1:0] : diff[DATA_W-1:0];
    step_quo  = {quo_q[DATA_W-2:0], ~borrow};
    rem_fix   = neg_rem_q ? -step_rem : step_rem;
    quo_fix   = neg_quo_q ? -step_quo : step_quo;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_div_in) begin
            state_d = div_zero_in ? S_DONE : S_DIV;
          end else begin
            state_d = (MUL_LAT == 1) ? S_DONE : S_MUL;
          end
        end
      end
      S_MUL: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == CW'(MUL_LAST)) begin
          state_d = S_DONE;
        end
      end
      S_DIV: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == CW'(DATA_W - 1)) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
`ifdef EX_MULDIV_MADD_EN
    acc_d     = acc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d     = '0;
          op_d      = op_i;
          a_d       = opa_i;
          b_d       = opb_i;
          rem_d     = '0;
          quo_d     = a_mag;
          dvs_d     = b_mag;
          neg_quo_d = sgn_in & (opa_i[DATA_W-1] ^ opb_i[DATA_W-1]);
          neg_rem_d = sgn_in & opa_i[DATA_W-1];
`ifdef EX_MULDIV_MADD_EN
          acc_d     = {hi_i, lo_i};
`endif
        end
      end
      S_MUL: cnt_d = cnt_q + 1'b1;
      S_DIV: begin
        cnt_d = cnt_q + 1'b1;
        rem_d = step_rem;
        quo_d = step_quo;
      end
      default: cnt_d = '0;
    endcase
    // Results land on the edge entering DONE; annul steers state_d away and so blocks the write.
    if (state_d == S_DONE && state_q != S_DONE) begin
      if (state_q == S_DIV) begin
        hi_d = rem_fix;
        lo_d = quo_fix;
      end else if (in_idle && is_div_in) begin
        hi_d = opa_i;
        lo_d = {DATA_W{1'b1}};
      end else begin
        {hi_d, lo_d} = mac;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
`ifdef EX_MULDIV_MADD_EN
      acc_q     <= '0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
`ifdef EX_MULDIV_MADD_EN
      acc_q     <= acc_d;
`endif
    end
  end

  always_comb begin
    stall_o = accept || (state_q == S_MUL) || (state_q == S_DIV);
    whilo_o = (state_q == S_DONE);
    hi_o    = hi_q;
    lo_o    = lo_q;
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - directed and randomised scoreboard bench for ex_muldiv (DATA_W=32, MUL_LAT=2)
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] opa_i = '0;
  logic [31:0] opb_i = '0;
  logic [31:0] hi_i = '0;
  logic [31:0] lo_i = '0;
  logic        annul_i = 1'b0;
  logic        stall_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        whilo_o;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_strobe = 0;
  logic [63:0] sb_q[$];
  logic [63:0] last_res = '0;

  ex_muldiv #(.DATA_W(32), .MUL_LAT(2)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .opa_i(opa_i), .opb_i(opb_i),
    .hi_i(hi_i), .lo_i(lo_i), .annul_i(annul_i), .stall_o(stall_o), .hi_o(hi_o),
    .lo_o(lo_o), .whilo_o(whilo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, b, h, l);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0]        p;
    if (op[2:1] == 2'b01) begin
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (!op[0]) begin
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
      end
      return {a % b, a / b};
    end
    if (!op[0]) p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    else        p = {32'd0, a} * {32'd0, b};
    if (!op[2]) return p;
    return op[1] ? ({h, l} - p) : ({h, l} + p);
  endfunction

  function automatic int lat_of(input logic [2:0] op, input logic [31:0] b);
    if (op[2:1] == 2'b01) return (b == 32'd0) ? 1 : 33;
    return 2;
  endfunction

  task automatic cyc();
    logic [63:0] exp;
    @(posedge clk);
    #1;
    if (whilo_o === 1'b1) begin
      n_strobe++;
      chk("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        exp = sb_q.pop_front();
        chk("result_hilo", {hi_o, lo_o}, exp);
        last_res = exp;
      end
    end
  endtask

  task automatic run_op(input bit adv, input logic [2:0] op, input logic [31:0] a, b, h, l,
                        input int lat, input logic [63:0] exp);
    if (adv) cyc();
    sb_q.push_back(exp);
    start_i = 1'b1; op_i = op; opa_i = a; opb_i = b; hi_i = h; lo_i = l; annul_i = 1'b0;
    #1;
    chk("stall_accept", 64'(stall_o), 64'd1);
    for (int k = 1; k <= lat; k++) begin
      cyc();
      chk("whilo_timing", 64'(whilo_o), 64'(k == lat));
      chk("stall_timing", 64'(stall_o), 64'(k < lat));
      if (k < lat) begin
        start_i = 1'($urandom_range(0, 1));
        op_i = 3'($urandom_range(0, 7));
        opa_i = $urandom; opb_i = $urandom; hi_i = $urandom; lo_i = $urandom;
      end else begin
        start_i = 1'b0;
      end
    end
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b, h, l;
    int          s0;

    #2;
    chk("reset_hilo", {hi_o, lo_o}, 64'd0);
    chk("reset_whilo", 64'(whilo_o), 64'd0);
    chk("reset_stall", 64'(stall_o), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;

    run_op(1, 3'b000, 32'hFFFF_FFFD, 32'd7, 0, 0, 2, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
    run_op(1, 3'b010, 32'hFFFF_FFF9, 32'd2, 0, 0, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(1, 3'b011, 32'd100, 32'd7, 0, 0, 33, {32'd2, 32'd14});
    run_op(1, 3'b011, 32'd5, 32'd0, 0, 0, 1, {32'd5, 32'hFFFF_FFFF});
    run_op(1, 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 33, {32'd0, 32'h8000_0000});
    run_op(1, 3'b010, 32'h1234_5678, 32'd0, 0, 0, 1, {32'h1234_5678, 32'hFFFF_FFFF});

    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(0, 3));
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      run_op(1, op, a, b, 0, 0, lat_of(op, b), model(op, a, b, 0, 0));
    end

    // Annul a DIV at T+10, then issue MULT 3*4 in T+11.
    cyc();
    start_i = 1'b1; op_i = 3'b010; opa_i = 32'd1000; opb_i = 32'd3;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      chk("annul_div_whilo", 64'(whilo_o), 64'd0);
      start_i = 1'b0;
      if (k == 10) annul_i = 1'b1;
    end
    cyc();
    annul_i = 1'b0;
    #1;
    chk("annul_div_stall", 64'(stall_o), 64'd0);
    chk("annul_div_whilo_after", 64'(whilo_o), 64'd0);
    chk("annul_div_hold", {hi_o, lo_o}, last_res);
    run_op(0, 3'b000, 32'd3, 32'd4, 0, 0, 2, {32'd0, 32'd12});

    // Annul in the cycle before DONE suppresses the strobe.
    cyc();
    start_i = 1'b1; op_i = 3'b001; opa_i = 32'd9; opb_i = 32'd9;
    cyc();
    chk("annul_mul_stall_t1", 64'(stall_o), 64'd1);
    start_i = 1'b0; annul_i = 1'b1;
    cyc();
    annul_i = 1'b0;
    #1;
    chk("annul_mul_whilo", 64'(whilo_o), 64'd0);
    chk("annul_mul_stall", 64'(stall_o), 64'd0);
    chk("annul_mul_hold", {hi_o, lo_o}, last_res);

    // start_i held through DONE yields one strobe.
    cyc();
    s0 = n_strobe;
    sb_q.push_back({32'd0, 32'd35});
    start_i = 1'b1; op_i = 3'b001; opa_i = 32'd5; opb_i = 32'd7;
    for (int k = 1; k <= 2; k++) cyc();
    cyc();
    start_i = 1'b0;
    for (int k = 0; k < 5; k++) cyc();
    chk("held_start_strobes", 64'(n_strobe - s0), 64'd1);

    // Reset in the middle of a DIV.
    cyc();
    start_i = 1'b1; op_i = 3'b011; opa_i = 32'd77; opb_i = 32'd5;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      start_i = 1'b0;
    end
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_hilo", {hi_o, lo_o}, 64'd0);
    chk("rst_mid_whilo", 64'(whilo_o), 64'd0);
    chk("rst_mid_stall", 64'(stall_o), 64'd0);
    last_res = '0;
    cyc();
    cyc();
    rst = 1'b1;
    s0 = n_strobe;
    for (int k = 0; k < 40; k++) cyc();
    chk("rst_no_strobe", 64'(n_strobe - s0), 64'd0);
    chk("rst_hold_zero", {hi_o, lo_o}, 64'd0);

    run_op(1, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 2, {32'hFFFF_FFFE, 32'h0000_0001});

`ifdef EX_MULDIV_MADD_EN
    run_op(1, 3'b101, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 2, {32'd1, 32'd0});
    for (int i = 0; i < 4; i++) begin
      op = 3'(4 + i);
      a = $urandom; b = $urandom; h = $urandom; l = $urandom;
      run_op(1, op, a, b, h, l, 2, model(op, a, b, h, l));
    end
`else
    cyc();
    s0 = n_strobe;
    start_i = 1'b1; op_i = 3'b101; opa_i = 32'd1; opb_i = 32'd1; hi_i = 32'd0; lo_i = 32'hFFFF_FFFF;
    #1;
    chk("maddu_off_stall", 64'(stall_o), 64'd0);
    for (int k = 0; k < 4; k++) cyc();
    start_i = 1'b0;
    for (int k = 0; k < 2; k++) cyc();
    chk("maddu_off_no_strobe", 64'(n_strobe - s0), 64'd0);
`endif

    cyc();
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
